// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared widths, control-bus bit positions and forwarding
//                select encodings for the RV64 pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;

    // Bit positions inside the packed control bus
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_READ   = 1;
    localparam int CTRL_MEM_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_BRANCH     = 5;
    localparam int CTRL_ALU_OP_LO  = 6;
    localparam int CTRL_ALU_OP_HI  = 7;

    // EX-stage operand mux selects
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/fwd_sel_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel_unit
//  Description : Combinational forwarding select for one EX operand.
//                EX/MEM beats MEM/WB; x0 is never forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW_P = REG_AW
) (
    input  logic [REG_AW_P-1:0] rs,
    input  logic [REG_AW_P-1:0] exmem_rd,
    input  logic                exmem_reg_write,
    input  logic [REG_AW_P-1:0] memwb_rd,
    input  logic                memwb_reg_write,
    input  logic                ex_valid,
    output logic [1:0]          sel
);

    // Pick the youngest producer of rs, falling back to register-file data
    always_comb begin
        sel = FWD_REGFILE;
        if (ex_valid) begin
            if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
                sel = FWD_EXMEM;
            end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
                sel = FWD_MEMWB;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_fwd_stage
//  Description : ID/EX pipeline register with forwarding-select generation
//                and load-use hazard detection (stall + bubble insertion).
//                Optional macro FWD_STATS_EN adds a saturating 32-bit count
//                of hazard bubbles on output bubble_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_fwd_stage
    import pipe_pkg::*;
#(
    parameter int XLEN_P   = XLEN,
    parameter int CTRL_W_P = CTRL_W,
    parameter int REG_AW_P = REG_AW
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                id_valid,
    input  logic [XLEN_P-1:0]   id_pc,
    input  logic [XLEN_P-1:0]   id_rs1_data,
    input  logic [XLEN_P-1:0]   id_rs2_data,
    input  logic [XLEN_P-1:0]   id_imm,
    input  logic [REG_AW_P-1:0] id_rs1,
    input  logic [REG_AW_P-1:0] id_rs2,
    input  logic [REG_AW_P-1:0] id_rd,
    input  logic [CTRL_W_P-1:0] id_ctrl,
    input  logic                flush,
    input  logic                ex_hold,
    input  logic [REG_AW_P-1:0] exmem_rd,
    input  logic                exmem_reg_write,
    input  logic [REG_AW_P-1:0] memwb_rd,
    input  logic                memwb_reg_write,
    output logic                ex_valid,
    output logic [XLEN_P-1:0]   ex_pc,
    output logic [XLEN_P-1:0]   ex_rs1_data,
    output logic [XLEN_P-1:0]   ex_rs2_data,
    output logic [XLEN_P-1:0]   ex_imm,
    output logic [REG_AW_P-1:0] ex_rs1,
    output logic [REG_AW_P-1:0] ex_rs2,
    output logic [REG_AW_P-1:0] ex_rd,
    output logic [CTRL_W_P-1:0] ex_ctrl,
    output logic [1:0]          fwd_a_sel,
    output logic [1:0]          fwd_b_sel,
`ifdef FWD_STATS_EN
    output logic [31:0]         bubble_cnt,
`endif
    output logic                stall
);

    logic                r_valid;
    logic [XLEN_P-1:0]   r_pc;
    logic [XLEN_P-1:0]   r_rs1_data;
    logic [XLEN_P-1:0]   r_rs2_data;
    logic [XLEN_P-1:0]   r_imm;
    logic [REG_AW_P-1:0] r_rs1;
    logic [REG_AW_P-1:0] r_rs2;
    logic [REG_AW_P-1:0] r_rd;
    logic [CTRL_W_P-1:0] r_ctrl;
    logic                w_hazard;

    // Load in EX whose destination is a source of the ID instruction
    assign w_hazard = r_valid && r_ctrl[CTRL_MEM_READ] && (r_rd != '0) && id_valid &&
                      ((r_rd == id_rs1) || (r_rd == id_rs2));

    assign stall = w_hazard || ex_hold;

    // Pipeline register: flush > hold > hazard bubble > capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
        end else if (flush || (!ex_hold && w_hazard)) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_ctrl     <= '0;
        end else if (!ex_hold) begin
            r_valid    <= id_valid;
            r_pc       <= id_pc;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_ctrl     <= id_valid ? id_ctrl : '0;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_ctrl     = r_ctrl;

    fwd_sel_unit #(.REG_AW_P(REG_AW_P)) u_fwd_a (
        .rs              (r_rs1),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .ex_valid        (r_valid),
        .sel             (fwd_a_sel)
    );

    fwd_sel_unit #(.REG_AW_P(REG_AW_P)) u_fwd_b (
        .rs              (r_rs2),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .ex_valid        (r_valid),
        .sel             (fwd_b_sel)
    );

`ifdef FWD_STATS_EN
    logic [31:0] r_bubble_cnt;

    // Count only hazard bubbles that actually get inserted; saturate at max
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bubble_cnt <= '0;
        end else if (!flush && !ex_hold && w_hazard && (r_bubble_cnt != 32'hFFFF_FFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_fwd_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_fwd_stage
//  Description : Directed self-checking bench for id_ex_fwd_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_fwd_stage;

    logic        clk;
    logic        reset_n;
    logic        id_valid;
    logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [7:0]  id_ctrl;
    logic        flush, ex_hold;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [7:0]  ex_ctrl;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall;
`ifdef FWD_STATS_EN
    logic [31:0] bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    id_ex_fwd_stage dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_pc           (id_pc),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_ctrl         (id_ctrl),
        .flush           (flush),
        .ex_hold         (ex_hold),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_rs1_data     (ex_rs1_data),
        .ex_rs2_data     (ex_rs2_data),
        .ex_imm          (ex_imm),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_ctrl         (ex_ctrl),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
`ifdef FWD_STATS_EN
        .bubble_cnt      (bubble_cnt),
`endif
        .stall           (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = pc + 64'h1000;
        id_rs2_data = pc + 64'h2000;
        id_imm      = pc + 64'h3000;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_ctrl     = ctrl;
    endtask

    task automatic clear_wb();
        exmem_rd = 5'd0; exmem_reg_write = 1'b0;
        memwb_rd = 5'd0; memwb_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        flush = 1'b0; ex_hold = 1'b0;
        clear_wb();
        drive_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 8'h00);
        #2;
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_pc !== 64'h0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: valid=%b ctrl=%h pc=%h stall=%b, want 0 0 0 0",
                     ex_valid, ex_ctrl, ex_pc, stall);
        end
        @(negedge clk);
        reset_n = 1'b1;
        // Load to x7 enters EX, then ID uses x7 -> stall up
        drive_id(1'b1, 64'h40, 5'd2, 5'd0, 5'd7, 8'h0B);
        step();
        drive_id(1'b1, 64'h44, 5'd7, 5'd3, 5'd8, 8'h01);
        #1;
        checks++;
        if (ex_valid !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_setup: valid=%b stall=%b, want 1 1", ex_valid, stall);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_pc !== 64'h0 || ex_rd !== 5'd0 ||
            ex_imm !== 64'h0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid=%b ctrl=%h pc=%h rd=%0d imm=%h stall=%b, want all 0",
                     ex_valid, ex_ctrl, ex_pc, ex_rd, ex_imm, stall);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drive_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 8'h00);
        step();
    endtask

    task automatic test_forwarding();
        // Instruction with rs1=5, rs2=0 enters EX
        drive_id(1'b1, 64'h100, 5'd5, 5'd0, 5'd6, 8'h01);
        step();
        drive_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 8'h00);
        exmem_rd = 5'd5; exmem_reg_write = 1'b1;
        memwb_rd = 5'd5; memwb_reg_write = 1'b1;
        #1;
        checks++;
        if (ex_pc !== 64'h100 || ex_rs1_data !== 64'h1100 || ex_rs2_data !== 64'h2100 ||
            ex_imm !== 64'h3100 || ex_rd !== 5'd6 || ex_ctrl !== 8'h01) begin
            errors++;
            $display("FAIL capture_fields: pc=%h d1=%h d2=%h imm=%h rd=%0d ctrl=%h, want 100 1100 2100 3100 6 01",
                     ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_ctrl);
        end
        checks++;
        if (fwd_a_sel !== 2'b10) begin
            errors++;
            $display("FAIL fwd_exmem_priority: got %b want 10", fwd_a_sel);
        end
        exmem_reg_write = 1'b0;
        #1;
        checks++;
        if (fwd_a_sel !== 2'b01) begin
            errors++;
            $display("FAIL fwd_memwb: got %b want 01", fwd_a_sel);
        end
        memwb_reg_write = 1'b0;
        #1;
        checks++;
        if (fwd_a_sel !== 2'b00) begin
            errors++;
            $display("FAIL fwd_regfile: got %b want 00", fwd_a_sel);
        end
        // x0 on rs2 with an EX/MEM write to x0
        exmem_rd = 5'd0; exmem_reg_write = 1'b1;
        #1;
        checks++;
        if (fwd_b_sel !== 2'b00) begin
            errors++;
            $display("FAIL fwd_x0: got %b want 00", fwd_b_sel);
        end
        clear_wb();
        // A bubble in EX forwards nothing
        step();
        exmem_rd = 5'd5; exmem_reg_write = 1'b1;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            errors++;
            $display("FAIL fwd_invalid: valid=%b a=%b b=%b, want 0 00 00", ex_valid, fwd_a_sel, fwd_b_sel);
        end
        clear_wb();
    endtask

    task automatic test_x0_load();
        drive_id(1'b1, 64'h200, 5'd1, 5'd0, 5'd0, 8'h0B);
        step();
        drive_id(1'b1, 64'h204, 5'd0, 5'd0, 5'd4, 8'h01);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL x0_no_hazard: stall=%b want 0", stall);
        end
        drive_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 8'h00);
        step();
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 64'h300, 5'd2, 5'd0, 5'd7, 8'h0B);
        step();
        drive_id(1'b1, 64'h304, 5'd7, 5'd3, 5'd8, 8'h01);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_stall: got %b want 1", stall);
        end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || stall !== 1'b0) begin
            errors++;
            $display("FAIL loaduse_bubble: valid=%b ctrl=%h stall=%b, want 0 00 0", ex_valid, ex_ctrl, stall);
        end
        // Load now sits in MEM/WB
        memwb_rd = 5'd7; memwb_reg_write = 1'b1;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_pc !== 64'h304 || ex_rs1 !== 5'd7 || ex_rd !== 5'd8 ||
            ex_ctrl !== 8'h01 || fwd_a_sel !== 2'b01 || stall !== 1'b0) begin
            errors++;
            $display("FAIL loaduse_replay: valid=%b pc=%h rs1=%0d rd=%0d ctrl=%h fa=%b stall=%b, want 1 304 7 8 01 01 0",
                     ex_valid, ex_pc, ex_rs1, ex_rd, ex_ctrl, fwd_a_sel, stall);
        end
        clear_wb();
        drive_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 8'h00);
        step();
    endtask

    task automatic test_priority();
        drive_id(1'b1, 64'h400, 5'd2, 5'd0, 5'd9, 8'h0B);
        step();
        drive_id(1'b1, 64'h404, 5'd9, 5'd0, 5'd10, 8'h01);
        flush = 1'b1; ex_hold = 1'b1;
        step();
        flush = 1'b0; ex_hold = 1'b0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00) begin
            errors++;
            $display("FAIL flush_wins: valid=%b ctrl=%h, want 0 00", ex_valid, ctrl_dummy(ex_ctrl));
        end
        // Capture a plain instruction, then hold for 3 cycles
        drive_id(1'b1, 64'h500, 5'd11, 5'd12, 5'd13, 8'h91);
        step();
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 64'h600 + 64'(i), 5'd14, 5'd15, 5'd16, 8'h05);
            #1;
            checks++;
            if (stall !== 1'b1) begin
                errors++;
                $display("FAIL hold_stall[%0d]: got %b want 1", i, stall);
            end
            step();
            checks++;
            if (ex_valid !== 1'b1 || ex_pc !== 64'h500 || ex_rs1 !== 5'd11 || ex_rs2 !== 5'd12 ||
                ex_rd !== 5'd13 || ex_ctrl !== 8'h91 || ex_imm !== 64'h3500) begin
                errors++;
                $display("FAIL hold_frozen[%0d]: valid=%b pc=%h rs1=%0d rs2=%0d rd=%0d ctrl=%h imm=%h, want 1 500 11 12 13 91 3500",
                         i, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_imm);
            end
        end
        ex_hold = 1'b0;
        drive_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 8'h00);
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || stall !== 1'b0) begin
            errors++;
            $display("FAIL invalid_capture: valid=%b ctrl=%h stall=%b, want 0 00 0", ex_valid, ex_ctrl, stall);
        end
    endtask

    function automatic logic [7:0] ctrl_dummy(input logic [7:0] c);
        return c;
    endfunction

`ifdef FWD_STATS_EN
    task automatic test_stats();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_id(1'b1, 64'h700, 5'd1, 5'd0, 5'd20, 8'h0B);
            step();
            drive_id(1'b1, 64'h704, 5'd20, 5'd0, 5'd21, 8'h01);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            drive_id(1'b1, 64'h800, 5'd1, 5'd0, 5'd0, 8'h01);
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        checks++;
        if (bubble_cnt !== 32'd4) begin
            errors++;
            $display("FAIL stats_count: got %0d want 4", bubble_cnt);
        end
        @(negedge clk);
        dut.r_bubble_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 64'h900, 5'd1, 5'd0, 5'd22, 8'h0B);
            step();
            drive_id(1'b1, 64'h904, 5'd22, 5'd0, 5'd23, 8'h01);
            step();
        end
        checks++;
        if (bubble_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stats_saturate: got %h want ffffffff", bubble_cnt);
        end
        drive_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 8'h00);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_x0_load();
        test_load_use();
        test_priority();
`ifdef FWD_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
